ml_if_fifo_buf: RTL and testbench
=================================

// Module: ml_if_fifo_buf
// PURPOSE
//  Input-feature buffer between IF SRAM and the PE array, driven by the control FSM via if_fifo_ctrl/if_fifo_resp.
//  Fill: fetches a tile of tile_len words from SRAM into a local FIFO. Drain: pops words to the PE IF register files,
//  tagging each with a wrapping row index. Reports "full" (fill done) and "empty" (drain done) back to the FSM.
// PARAMETERS
//  DATA_W  16  IF word width
//  DEPTH   16  FIFO entries (power of 2); max tile length
//  ADDR_W  12  SRAM word-address width
//  Y_DIM   15  PE rows; pe_if_row wraps at Y_DIM-1
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    synchronous, active-high reset
//  if_fifo_ctrl   in   2                    [0]=fill request (level), [1]=drain request (level, 1 pop/cycle)
//  if_fifo_resp   out  2                    [0]=full (level), [1]=drain-done (1-cycle pulse)
//  base_addr      in   ADDR_W               tile start address; sampled when fill starts
//  tile_len       in   $clog2(DEPTH+1)      words to fetch; sampled when fill starts
//  sram_rd_en     out  1                    SRAM read strobe
//  sram_addr      out  ADDR_W               SRAM read address
//  sram_rd_data   in   DATA_W               read data, valid exactly 1 cycle after sram_rd_en
//  pe_if_valid    out  1                    pe_if_data/pe_if_row valid this cycle
//  pe_if_data     out  DATA_W               popped word
//  pe_if_row      out  $clog2(Y_DIM)        target PE row for pe_if_data
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pointers/count/issue counter/row counter 0; in-flight read-valid pipe cleared.
//  States: IDLE -> FETCH -> FULL -> DRAIN -> IDLE.
//  IDLE: ctrl[0]=1 -> latch base_addr, len=min(tile_len,DEPTH), clear FIFO and row counter; next FETCH.
//        len=0 -> next FULL directly. ctrl[0] and ctrl[1] together -> fill wins. ctrl[1] alone ignored.
//  FETCH: sram_rd_en=1 with sram_addr=base+issue_cnt each cycle while issue_cnt<len (back-to-back, no gaps).
//        Word is written to the FIFO the cycle it returns (rd_en delayed 1). When write count==len -> FULL.
//        Latency: request sampled cycle 0 -> rd_en cycles 1..N -> resp[0] high from cycle N+2.
//        ctrl[0]/ctrl[1] ignored in FETCH. Address arithmetic wraps mod 2^ADDR_W.
//  FULL: resp[0]=1 (level, registered). Pop permitted. First pop -> DRAIN; resp[0] drops the cycle after that pop.
//  FULL/DRAIN pop: ctrl[1]=1 and count>0 -> pop one word. Next cycle: pe_if_valid=1, pe_if_data=word,
//        pe_if_row=row counter (then row++, wrap Y_DIM-1 -> 0). ctrl[1]=0 -> stall; no pop, pe_if_valid=0.
//  Drain done: cycle after the pop that empties the FIFO -> resp[1]=1 for one cycle; state -> IDLE.
//        len=0: ctrl[1] in FULL -> resp[1] pulse next cycle, no pe_if_valid.
//  ctrl[0] in FULL/DRAIN ignored (no refill over unconsumed data).
//  Reset mid-operation: returns to IDLE immediately; SRAM data returning next cycle discarded.
//  No overflow possible (len<=DEPTH); pop on empty never occurs by construction — assert it.
// STRUCTURE
//  ml_acc_pkg: buffer state enum; IF_CTRL_FILL=0, IF_CTRL_DRAIN=1, IF_RESP_FULL=0, IF_RESP_DONE=1 bit indices.
//  Sub-module ml_sync_fifo (DATA_W, DEPTH): 1-write/1-read sync FIFO with count, registered read data.
//  Top holds FSM, address/issue counter, 1-cycle read-valid pipe, row counter.
// TESTING (SRAM model returns data = {4'hA, addr})
//  1 Fill 4 @0x010, then ctrl[1] held -> rd_en cycles 1-4 addr 0x010..0x013; resp[0] at cycle 6;
//    pe_if_data 0xA010..0xA013 on 4 consecutive cycles, rows 0..3; resp[1] pulse after last.
//  2 tile_len=0 -> resp[0] 1 cycle after request; ctrl[1] -> resp[1] pulse, pe_if_valid never high.
//  3 tile_len=20, DEPTH=16 -> exactly 16 reads 0x000..0x00F; 16 pops; resp[1] after 16th.
//  4 Drain 4 words with ctrl[1] pattern 1,0,0,1,1,0,1 -> 4 valid words in order, gaps where ctrl[1]=0.
//  5 Y_DIM=3, fill/drain 5 words -> pe_if_row 0,1,2,0,1.
//  6 rst at 2nd rd_en cycle, then fill 2 @0x100 -> only 0xA100,0xA101 drained; no stale word, all outputs 0 during rst.

Source files
------------

// File: rtl/ml_acc_pkg.sv
// Shared constants for the accelerator IF buffer: buffer FSM encoding and
// bit positions inside the control/response handshake vectors.
package ml_acc_pkg;

  typedef logic [1:0] buf_state_t;

  localparam buf_state_t ST_IDLE  = 2'd0;
  localparam buf_state_t ST_FETCH = 2'd1;
  localparam buf_state_t ST_FULL  = 2'd2;
  localparam buf_state_t ST_DRAIN = 2'd3;

  localparam int IF_CTRL_FILL  = 0;
  localparam int IF_CTRL_DRAIN = 1;
  localparam int IF_RESP_FULL  = 0;
  localparam int IF_RESP_DONE  = 1;

endpackage

// File: rtl/ml_sync_fifo.sv
// Single-clock FIFO, one write and one read port, occupancy count and
// registered read data (block-RAM friendly).
module ml_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;

  // The owner only pops when data is present and never writes past the tile length.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) rd_en |-> count_reg != '0);
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                                   (wr_en && !rd_en) |-> count_reg != CNT_W'(DEPTH));

endmodule

// File: rtl/ml_if_fifo_buf.sv
// Input-feature buffer: fetches a tile from IF SRAM into a local FIFO, then
// drains it to the PE array one word per cycle with a wrapping row tag.
module ml_if_fifo_buf
  import ml_acc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 12,
  parameter int Y_DIM  = 15,
  localparam int LEN_W = $clog2(DEPTH + 1),
  localparam int ROW_W = $clog2(Y_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        if_fifo_ctrl,
  output logic [1:0]        if_fifo_resp,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  tile_len,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              pe_if_valid,
  output logic [DATA_W-1:0] pe_if_data,
  output logic [ROW_W-1:0]  pe_if_row
);

  buf_state_t        state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  issue_cnt_reg;
  logic [LEN_W-1:0]  wr_cnt_reg;
  logic              rd_valid_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [ROW_W-1:0]  pe_row_reg;
  logic              pe_valid_reg;
  logic              full_reg;
  logic              done_reg;

  logic              fill_req;
  logic              drain_req;
  logic              issue;
  logic              pop;
  logic              fill_start;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  fifo_count;

  assign fill_req    = if_fifo_ctrl[IF_CTRL_FILL];
  assign drain_req   = if_fifo_ctrl[IF_CTRL_DRAIN];
  assign len_clamped = (tile_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : tile_len;
  assign fill_start  = (state_reg == ST_IDLE) && fill_req;
  assign issue       = (state_reg == ST_FETCH) && (issue_cnt_reg < len_reg);
  assign pop         = ((state_reg == ST_FULL) || (state_reg == ST_DRAIN))
                       && drain_req && (fifo_count != '0);

  ml_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (fill_start),
    .wr_en   (rd_valid_reg),
    .wr_data (sram_rd_data),
    .rd_en   (pop),
    .rd_data (pe_if_data),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      wr_cnt_reg    <= '0;
      rd_valid_reg  <= 1'b0;
      row_reg       <= '0;
      pe_row_reg    <= '0;
      pe_valid_reg  <= 1'b0;
      full_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // SRAM data lands exactly one cycle after the strobe.
      rd_valid_reg <= issue;
      pe_valid_reg <= pop;
      done_reg     <= 1'b0;
      if (pop) begin
        pe_row_reg <= row_reg;
        row_reg    <= (row_reg == ROW_W'(Y_DIM - 1)) ? '0 : row_reg + ROW_W'(1);
      end
      case (state_reg)
        ST_IDLE: begin
          if (fill_req) begin
            base_reg      <= base_addr;
            len_reg       <= len_clamped;
            issue_cnt_reg <= '0;
            wr_cnt_reg    <= '0;
            row_reg       <= '0;
            if (len_clamped == '0) begin
              state_reg <= ST_FULL;
              full_reg  <= 1'b1;
            end else begin
              state_reg <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (issue) issue_cnt_reg <= issue_cnt_reg + LEN_W'(1);
          if (rd_valid_reg) begin
            wr_cnt_reg <= wr_cnt_reg + LEN_W'(1);
            if (wr_cnt_reg == len_reg - LEN_W'(1)) begin
              state_reg <= ST_FULL;
              full_reg  <= 1'b1;
            end
          end
        end
        ST_FULL, ST_DRAIN: begin
          // A drain request on an empty (zero-length) tile still completes the handshake.
          if (drain_req) begin
            full_reg <= 1'b0;
            if (fifo_count <= LEN_W'(1)) begin
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sram_rd_en                 = issue;
  assign sram_addr                  = issue ? base_reg + ADDR_W'(issue_cnt_reg) : '0;
  assign pe_if_valid                = pe_valid_reg;
  assign pe_if_row                  = pe_row_reg;
  assign if_fifo_resp[IF_RESP_FULL] = full_reg;
  assign if_fifo_resp[IF_RESP_DONE] = done_reg;

endmodule

// File: tb/tb_ml_if_fifo_buf.sv
// Bench for ml_if_fifo_buf: two instances (Y_DIM 15 and 3) share stimulus; a
// scoreboard of expected SRAM addresses and drained words is checked on output.
module tb_ml_if_fifo_buf;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        ctrl;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;

  logic [1:0]        resp,    resp3;
  logic              rd_en,   rd_en3;
  logic [ADDR_W-1:0] addr,    addr3;
  logic [DATA_W-1:0] rd_data, rd_data3;
  logic              pv,      pv3;
  logic [DATA_W-1:0] pd,      pd3;
  logic [3:0]        prow;
  logic [1:0]        prow3;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [ADDR_W-1:0] addr3_q[$];
  logic [DATA_W-1:0] data_q[$];
  logic [DATA_W-1:0] data3_q[$];
  logic [3:0]        row_q[$];
  logic [1:0]        row3_q[$];

  always #5 clk = ~clk;

  ml_if_fifo_buf dut (
    .clk(clk), .rst(rst), .if_fifo_ctrl(ctrl), .if_fifo_resp(resp),
    .base_addr(base), .tile_len(len), .sram_rd_en(rd_en), .sram_addr(addr),
    .sram_rd_data(rd_data), .pe_if_valid(pv), .pe_if_data(pd), .pe_if_row(prow)
  );

  ml_if_fifo_buf #(.Y_DIM(3)) dut_y3 (
    .clk(clk), .rst(rst), .if_fifo_ctrl(ctrl), .if_fifo_resp(resp3),
    .base_addr(base), .tile_len(len), .sram_rd_en(rd_en3), .sram_addr(addr3),
    .sram_rd_data(rd_data3), .pe_if_valid(pv3), .pe_if_data(pd3), .pe_if_row(prow3)
  );

  // SRAM model: one-cycle read latency, data = {4'hA, addr}.
  always_ff @(posedge clk) begin
    rd_data  <= {4'hA, addr};
    rd_data3 <= {4'hA, addr3};
  end

  // Output monitors pop the scoreboard whenever the DUT reads or emits a word.
  always @(negedge clk) begin : mon
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [3:0]        er;
    logic [1:0]        er3;
    if (rst === 1'b0) begin
      if (rd_en === 1'b1) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++; $display("FAIL sram_addr: got read of %h, required no read", addr);
        end else begin
          ea = addr_q.pop_front();
          if (addr !== ea) begin errors++; $display("FAIL sram_addr: got %h, required %h", addr, ea); end
        end
      end
      if (rd_en3 === 1'b1) begin
        checks++;
        if (addr3_q.size() == 0) begin
          errors++; $display("FAIL sram_addr_y3: got read of %h, required no read", addr3);
        end else begin
          ea = addr3_q.pop_front();
          if (addr3 !== ea) begin errors++; $display("FAIL sram_addr_y3: got %h, required %h", addr3, ea); end
        end
      end
      if (pv === 1'b1) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++; $display("FAIL pe_word: got data=%h row=%0d, required no word", pd, prow);
        end else begin
          ed = data_q.pop_front();
          er = row_q.pop_front();
          if (pd !== ed || prow !== er) begin
            errors++; $display("FAIL pe_word: got data=%h row=%0d, required data=%h row=%0d", pd, prow, ed, er);
          end
        end
      end
      if (pv3 === 1'b1) begin
        checks++;
        if (data3_q.size() == 0) begin
          errors++; $display("FAIL pe_word_y3: got data=%h row=%0d, required no word", pd3, prow3);
        end else begin
          ed  = data3_q.pop_front();
          er3 = row3_q.pop_front();
          if (pd3 !== ed || prow3 !== er3) begin
            errors++; $display("FAIL pe_word_y3: got data=%h row=%0d, required data=%h row=%0d", pd3, prow3, ed, er3);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sb();
    addr_q.delete(); addr3_q.delete(); data_q.delete(); data3_q.delete();
    row_q.delete(); row3_q.delete();
  endtask

  // Pulses a fill request for one cycle and records what the fill must produce.
  task automatic start_fill(input logic [ADDR_W-1:0] b, input int n);
    int m;
    logic [ADDR_W-1:0] a;
    m = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < m; i++) begin
      a = b + ADDR_W'(i);
      addr_q.push_back(a);
      addr3_q.push_back(a);
      data_q.push_back({4'hA, a});
      data3_q.push_back({4'hA, a});
      row_q.push_back(4'(i % 15));
      row3_q.push_back(2'(i % 3));
    end
    base    = b;
    len     = LEN_W'(n);
    ctrl[0] = 1'b1;
    step();
    ctrl[0] = 1'b0;
    $display("fill base=%h len=%0d expected_words=%0d", b, n, m);
  endtask

  task automatic wait_resp(input int idx, input int budget, output bit ok);
    int t;
    t = 0;
    while (resp[idx] !== 1'b1 && t < budget) begin step(); t++; end
    ok = (resp[idx] === 1'b1);
  endtask

  task automatic drain_all(input int budget, output bit ok);
    ctrl[1] = 1'b1;
    wait_resp(1, budget, ok);
    ctrl[1] = 1'b0;
  endtask

  task automatic check_sb_empty(input string tag);
    checks++;
    if (data_q.size() != 0 || data3_q.size() != 0 || addr_q.size() != 0 || addr3_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d/%0d words and %0d/%0d reads outstanding, required 0",
               tag, data_q.size(), data3_q.size(), addr_q.size(), addr3_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (resp !== 2'b00 || rd_en !== 1'b0 || addr !== '0 || pv !== 1'b0 || pd !== '0 || prow !== '0) begin
      errors++;
      $display("FAIL %s_outputs: got resp=%b rd_en=%b addr=%h pv=%b pd=%h row=%0d, required all 0",
               tag, resp, rd_en, addr, pv, pd, prow);
    end
    checks++;
    if (resp3 !== 2'b00 || rd_en3 !== 1'b0 || addr3 !== '0 || pv3 !== 1'b0 || pd3 !== '0 || prow3 !== '0) begin
      errors++;
      $display("FAIL %s_outputs_y3: got resp=%b rd_en=%b addr=%h pv=%b pd=%h row=%0d, required all 0",
               tag, resp3, rd_en3, addr3, pv3, pd3, prow3);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ctrl = 2'b00; base = '0; len = '0;
    repeat (3) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    start_fill(12'h010, 4);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (rd_en !== 1'(c <= 4)) begin
        errors++; $display("FAIL t1_rd_en cycle %0d: got %b, required %b", c, rd_en, c <= 4);
      end
      checks++;
      if (resp[0] !== 1'(c >= 6)) begin
        errors++; $display("FAIL t1_full cycle %0d: got %b, required %b", c, resp[0], c >= 6);
      end
      if (c < 6) step();
    end
    ctrl[1] = 1'b1;
    for (int c = 7; c <= 11; c++) begin
      step();
      checks++;
      if (pv !== 1'(c <= 10) || resp[1] !== 1'(c == 10) || resp[0] !== 1'b0) begin
        errors++;
        $display("FAIL t1_drain cycle %0d: got valid=%b done=%b full=%b, required valid=%b done=%b full=0",
                 c, pv, resp[1], resp[0], c <= 10, c == 10);
      end
    end
    ctrl[1] = 1'b0;
    check_sb_empty("t1");
    $display("test_fill_drain done");
  endtask

  task automatic test_zero_len();
    start_fill(12'h050, 0);
    checks++;
    if (resp[0] !== 1'b1 || rd_en !== 1'b0) begin
      errors++; $display("FAIL t2_full: got full=%b rd_en=%b, required full=1 rd_en=0", resp[0], rd_en);
    end
    ctrl[1] = 1'b1;
    step();
    checks++;
    if (resp !== 2'b10 || pv !== 1'b0 || resp3 !== 2'b10) begin
      errors++; $display("FAIL t2_done: got resp=%b resp_y3=%b valid=%b, required resp=10 valid=0", resp, resp3, pv);
    end
    ctrl[1] = 1'b0;
    step();
    checks++;
    if (resp !== 2'b00) begin
      errors++; $display("FAIL t2_done_pulse: got resp=%b, required 00", resp);
    end
    check_sb_empty("t2");
    $display("test_zero_len done");
  endtask

  task automatic test_clamp();
    bit ok;
    start_fill(12'h000, 20);
    wait_resp(0, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t3_full_timeout: got full=%b, required 1", resp[0]); end
    drain_all(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t3_done_timeout: got done=%b, required 1", resp[1]); end
    step();
    check_sb_empty("t3");
    $display("test_clamp done");
  endtask

  task automatic test_stall();
    bit ok;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    start_fill(12'h020, 4);
    wait_resp(0, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t4_full_timeout: got full=%b, required 1", resp[0]); end
    for (int i = 0; i < 7; i++) begin
      ctrl[1] = pat[i];
      step();
      checks++;
      if (pv !== pat[i]) begin
        errors++; $display("FAIL t4_valid step %0d: got %b, required %b", i, pv, pat[i]);
      end
    end
    ctrl[1] = 1'b0;
    checks++;
    if (resp[1] !== 1'b1) begin
      errors++; $display("FAIL t4_done: got %b, required 1", resp[1]);
    end
    step();
    check_sb_empty("t4");
    $display("test_stall done");
  endtask

  task automatic test_row_wrap();
    bit ok;
    start_fill(12'h030, 5);
    wait_resp(0, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t5_full_timeout: got full=%b, required 1", resp[0]); end
    drain_all(30, ok);
    checks++;
    if (!ok || resp3[1] !== 1'b1) begin
      errors++; $display("FAIL t5_done: got done=%b done_y3=%b, required 1 1", resp[1], resp3[1]);
    end
    step();
    check_sb_empty("t5");
    $display("test_row_wrap done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_fill(12'h200, 4);
    step();
    checks++;
    if (rd_en !== 1'b1 || addr !== 12'h201) begin
      errors++; $display("FAIL t6_second_read: got rd_en=%b addr=%h, required 1 201", rd_en, addr);
    end
    rst = 1'b1;
    step();
    check_outputs_zero("t6_rst");
    step();
    check_outputs_zero("t6_rst_hold");
    rst = 1'b0;
    flush_sb();
    step();
    start_fill(12'h100, 2);
    wait_resp(0, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_full_timeout: got full=%b, required 1", resp[0]); end
    drain_all(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_done_timeout: got done=%b, required 1", resp[1]); end
    step();
    check_sb_empty("t6");
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_zero_len();
    test_clamp();
    test_stall();
    test_row_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
